// File: rtl/exec_seq.sv
// exec_seq: four-state instruction sequencer (IDLE/READ/EXEC/WRITE) driving a 2-read/1-write register file.
// Define EXEC_SEQ_MUL_EN to make opcode 9 a MUL; otherwise opcode 9 is illegal.
module exec_seq #(
    parameter int DATA_W = 32,
    parameter int ADR_W  = 5
) (
    input  logic              clkout,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [ADR_W-1:0]  mem_addr1,
    output logic [ADR_W-1:0]  mem_addr2,
    output logic              wr,
    output logic [DATA_W-1:0] reg_din,
    input  logic [DATA_W-1:0] reg_out,
    input  logic [DATA_W-1:0] op_reg,
    output logic              done,
    output logic              zero,
    output logic              carry,
    output logic              err,
    output logic [1:0]        state_dbg
);

    // Handshake: an instruction transfers on a rising edge where instr_valid and instr_ready are both 1;
    // instr_ready is high only in IDLE, and instr is not looked at on any other edge.
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    state_t             state, state_nx;
    logic               done_nx;
    logic [3:0]         op_q;
    logic [ADR_W-1:0]   rd_q, rs_q;
    logic [DATA_W-1:0]  result_q;
    logic [DATA_W-1:0]  alu_res;
    logic [DATA_W:0]    alu_sum;
    logic               alu_c, alu_legal, alu_wb;
    logic               unused_bits;

    assign unused_bits = ^instr[1:0];
    assign state_dbg   = state;

    // Result, carry and write-back decision for the latched opcode.
    always_comb begin
        alu_res   = '0;
        alu_sum   = '0;
        alu_c     = 1'b0;
        alu_legal = 1'b1;
        alu_wb    = 1'b1;
        case (op_q)
            4'd0: begin
                alu_sum = {1'b0, reg_out} + {1'b0, op_reg};
                alu_res = alu_sum[DATA_W-1:0];
                alu_c   = alu_sum[DATA_W];
            end
            4'd1: begin
                alu_res = reg_out - op_reg;
                alu_c   = (reg_out < op_reg);
            end
            4'd2: alu_res = reg_out & op_reg;
            4'd3: alu_res = reg_out | op_reg;
            4'd4: alu_res = reg_out ^ op_reg;
            4'd5: alu_res = op_reg;
            4'd6: alu_res = reg_out << op_reg[4:0];
            4'd7: alu_res = reg_out >> op_reg[4:0];
            4'd8: begin
                alu_res = reg_out - op_reg;
                alu_c   = (reg_out < op_reg);
                alu_wb  = 1'b0;
            end
`ifdef EXEC_SEQ_MUL_EN
            4'd9: alu_res = reg_out * op_reg;
`endif
            default: begin
                alu_legal = 1'b0;
                alu_wb    = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        unique case (state)
            IDLE:  if (instr_valid) state_nx = READ;
            READ:  state_nx = EXEC;
            EXEC: begin
                if (alu_wb) begin
                    state_nx = WRITE;
                end else begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            WRITE: begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clkout) begin
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            err      <= 1'b0;
            result_q <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
        end else begin
            state <= state_nx;
            done  <= done_nx;
            if (state == IDLE && instr_valid) begin
                op_q <= instr[15:12];
                rd_q <= ADR_W'(instr[11:7]);
                rs_q <= ADR_W'(instr[6:2]);
            end
            // Illegal opcodes only raise err; zero/carry and the result keep their old values.
            if (state == EXEC) begin
                if (alu_legal) begin
                    result_q <= alu_res;
                    zero     <= (alu_res == '0);
                    carry    <= alu_c;
                    err      <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    // wr is masked by rst_n so a reset landing on the write edge aborts the write.
    always_comb begin
        instr_ready = (state == IDLE);
        wr          = 1'b0;
        mem_addr1   = '0;
        mem_addr2   = '0;
        reg_din     = '0;
        case (state)
            READ: begin
                mem_addr1 = rd_q;
                mem_addr2 = rs_q;
            end
            WRITE: begin
                wr        = rst_n;
                mem_addr1 = rd_q;
                reg_din   = result_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exec_seq.sv
// tb_exec_seq: drives exec_seq against a behavioural register file and an instruction-level reference model.
// Directed scenarios pin the model with literal results; a randomized phase follows.
module tb_exec_seq;

    logic        clkout = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic [4:0]  mem_addr1, mem_addr2;
    logic        wr;
    logic [31:0] reg_din;
    logic [31:0] reg_out = '0;
    logic [31:0] op_reg = '0;
    logic        done, zero, carry, err;
    logic [1:0]  state_dbg;

    exec_seq #(.DATA_W(32), .ADR_W(5)) dut (
        .clkout      (clkout),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .mem_addr1   (mem_addr1),
        .mem_addr2   (mem_addr2),
        .wr          (wr),
        .reg_din     (reg_din),
        .reg_out     (reg_out),
        .op_reg      (op_reg),
        .done        (done),
        .zero        (zero),
        .carry       (carry),
        .err         (err),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clkout = ~clkout;

    int   cyc = 0;
    logic rst_edge = 1'b0;
    always @(posedge clkout) begin
        cyc      <= cyc + 1;
        rst_edge <= !rst_n;
    end

    // ---------------- register file environment ----------------
    logic [31:0] rf [32];
    logic        tb_we = 1'b0;
    logic [4:0]  tb_wa = '0;
    logic [31:0] tb_wd = '0;
    always @(posedge clkout) begin
        if (wr) rf[mem_addr1] <= reg_din;
        if (tb_we) rf[tb_wa] <= tb_wd;
        reg_out <= rf[mem_addr1];
        op_reg  <= rf[mem_addr2];
    end

    // ---------------- reference model state ----------------
    logic [31:0] gold [32];
    bit          m_zero = 1'b0, m_carry = 1'b0, m_err = 1'b0;
    bit          p_active = 1'b0, p_wb = 1'b0;
    int          p_acc = 0, p_lat = 0;
    logic [4:0]  p_rd = '0, p_rs = '0;
    logic [31:0] p_res = '0;
    bit          p_z = 1'b0, p_c = 1'b0, p_e = 1'b0;

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Instruction semantics straight from the opcode table.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input bit z0, input bit c0,
                                  output logic [31:0] r, output bit wb, output bit z, output bit c, output bit e);
        logic [32:0] s;
        bit legal;
        r = '0; wb = 1'b1; c = 1'b0; legal = 1'b1;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
            4'd1: begin r = a - b; c = (a < b); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = b;
            4'd6: r = a << b[4:0];
            4'd7: r = a >> b[4:0];
            4'd8: begin r = a - b; c = (a < b); wb = 1'b0; end
`ifdef EXEC_SEQ_MUL_EN
            4'd9: r = a * b;
`endif
            default: legal = 1'b0;
        endcase
        if (legal) begin
            z = (r == 0); e = 1'b0;
        end else begin
            wb = 1'b0; z = z0; c = c0; e = 1'b1;
        end
    endfunction

    // ---------------- scoreboard: compare every cycle ----------------
    int d;
    bit exp_z, exp_c, exp_e;
    always @(negedge clkout) begin
        if (rst_edge) begin
            check("rst_ready", instr_ready, 1);
            check("rst_done", done, 0);
            check("rst_wr", wr, 0);
            check("rst_flags", {zero, carry, err}, 0);
            check("rst_addr", {mem_addr1, mem_addr2}, 0);
            p_active = 1'b0;
            m_zero = 1'b0; m_carry = 1'b0; m_err = 1'b0;
        end else begin
            d = cyc - p_acc;
            if (p_active && d >= 2) begin
                exp_z = p_z; exp_c = p_c; exp_e = p_e;
            end else begin
                exp_z = m_zero; exp_c = m_carry; exp_e = m_err;
            end
            check("ready", instr_ready, (!p_active || d >= p_lat));
            check("done", done, (p_active && d == p_lat));
            check("wr", wr, (p_active && p_wb && d == 2 && rst_n));
            if (p_active && d == 0) begin
                check("rd_addr1", mem_addr1, p_rd);
                check("rd_addr2", mem_addr2, p_rs);
            end
            if (p_active && p_wb && d == 2) begin
                check("wr_addr1", mem_addr1, p_rd);
                check("reg_din", reg_din, p_res);
            end
            check("zero", zero, exp_z);
            check("carry", carry, exp_c);
            check("err", err, exp_e);
            if (p_active && d == p_lat) begin
                if (p_wb) gold[p_rd] = p_res;
                m_zero = p_z; m_carry = p_c; m_err = p_e;
                p_active = 1'b0;
            end
        end
    end

    // ---------------- driver tasks (all enter/leave at posedge+1) ----------------
    task automatic step();
        @(posedge clkout); #1;
    endtask

    task automatic set_reg(input logic [4:0] a, input logic [31:0] v);
        tb_we = 1'b1; tb_wa = a; tb_wd = v;
        step();
        tb_we = 1'b0;
        gold[a] = v;
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs);
        int n;
        n = 0;
        while (!instr_ready && n < 40) begin step(); n++; end
        if (!instr_ready) begin
            chk_cnt++;
            $display("FAIL ready_timeout: instr_ready stayed 0 for %0d cycles, required 1", n);
        end else begin
            instr_valid = 1'b1;
            instr = {op, rd, rs, 2'($urandom_range(0, 3))};
            step();
            instr_valid = 1'b0;
            model(op, gold[rd], gold[rs], m_zero, m_carry, p_res, p_wb, p_z, p_c, p_e);
            p_rd = rd; p_rs = rs;
            p_lat = p_wb ? 3 : 2;
            p_acc = cyc;
            p_active = 1'b1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (p_active && n < 40) begin step(); n++; end
        if (p_active) begin
            chk_cnt++;
            $display("FAIL retire_timeout: instruction pending for %0d cycles, required retire", n);
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) set_reg(5'(i), $urandom);

        // ADD r1=5 + r2=7
        set_reg(1, 32'd5); set_reg(2, 32'd7);
        issue(4'd0, 5'd1, 5'd2); wait_idle();
        check("add_r1", rf[1], 32'd12);
        check("add_zero", zero, 0);
        check("add_carry", carry, 0);

        // ADD overflow wraps to zero with carry
        set_reg(3, 32'hFFFF_FFFF); set_reg(4, 32'd1);
        issue(4'd0, 5'd3, 5'd4); wait_idle();
        check("ovf_r3", rf[3], 32'd0);
        check("ovf_zero", zero, 1);
        check("ovf_carry", carry, 1);

        // CMP 3 vs 9: borrow, no write-back
        set_reg(5, 32'd3); set_reg(6, 32'd9);
        issue(4'd8, 5'd5, 5'd6); wait_idle();
        check("cmp_r5", rf[5], 32'd3);
        check("cmp_carry", carry, 1);
        check("cmp_zero", zero, 0);

        // Illegal opcode keeps carry from the CMP
        issue(4'hF, 5'd0, 5'd0); wait_idle();
        check("ill_err", err, 1);
        check("ill_carry", carry, 1);

        // MOV clears err
        set_reg(1, 32'd5);
        issue(4'd5, 5'd8, 5'd1); wait_idle();
        check("mov_r8", rf[8], 32'd5);
        check("mov_err", err, 0);

        // rd == rs
        set_reg(9, 32'd21);
        issue(4'd0, 5'd9, 5'd9); wait_idle();
        check("same_r9", rf[9], 32'd42);

        // Reset while SUB is in WRITE aborts the write
        set_reg(2, 32'd7); set_reg(1, 32'd2);
        issue(4'd1, 5'd2, 5'd1);
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("abort_r2", rf[2], 32'd7);
        check("abort_ready", instr_ready, 1);
        check("abort_done", done, 0);

        // Opcode 9
        set_reg(1, 32'd6); set_reg(2, 32'd7);
        issue(4'd9, 5'd1, 5'd2); wait_idle();
`ifdef EXEC_SEQ_MUL_EN
        check("mul_r1", rf[1], 32'd42);
        check("mul_err", err, 0);
`else
        check("op9_r1", rf[1], 32'd6);
        check("op9_err", err, 1);
`endif

        // Randomized traffic, back-to-back or with gaps, occasional mid-flight resets
        for (int k = 0; k < 250; k++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) set_reg(5'($urandom_range(0, 31)), $urandom_range(0, 3));
            issue(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 24) == 0) begin
                repeat ($urandom_range(0, 2)) step();
                reset_pulse();
            end
            repeat ($urandom_range(0, 2)) step();
        end
        wait_idle();
        step();
        for (int i = 0; i < 32; i++) check("final_rf", rf[i], gold[i]);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
